// File: rtl/z80_block_op_engine_if.sv
// Launch snapshot, result and memory handshake bundle for the Z80 block-op engine.
// Z80_BLOCK_INTR_EN adds int_pend/interrupted.
interface z80_block_op_engine_if #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
);
    logic              start;
    logic              op_cp;
    logic              op_dec;
    logic              op_rep;
    logic [7:0]        a_in;
    logic [7:0]        f_in;
    logic [CNT_W-1:0]  bc_in;
    logic [ADDR_W-1:0] de_in;
    logic [ADDR_W-1:0] hl_in;

    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_rd_ack;
    logic [7:0]        mem_rd_data;
    logic              mem_wr_req;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [7:0]        mem_wr_data;
    logic              mem_wr_ack;

    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  bc_out;
    logic [ADDR_W-1:0] de_out;
    logic [ADDR_W-1:0] hl_out;
    logic [7:0]        f_out;
    logic [CNT_W-1:0]  iter_cnt;

`ifdef Z80_BLOCK_INTR_EN
    logic              int_pend;
    logic              interrupted;

    modport master (
        output start, op_cp, op_dec, op_rep, a_in, f_in, bc_in, de_in, hl_in,
        output mem_rd_ack, mem_rd_data, mem_wr_ack, int_pend,
        input  mem_rd_req, mem_rd_addr, mem_wr_req, mem_wr_addr, mem_wr_data,
        input  busy, done, bc_out, de_out, hl_out, f_out, iter_cnt, interrupted
    );

    modport slave (
        input  start, op_cp, op_dec, op_rep, a_in, f_in, bc_in, de_in, hl_in,
        input  mem_rd_ack, mem_rd_data, mem_wr_ack, int_pend,
        output mem_rd_req, mem_rd_addr, mem_wr_req, mem_wr_addr, mem_wr_data,
        output busy, done, bc_out, de_out, hl_out, f_out, iter_cnt, interrupted
    );
`else
    modport master (
        output start, op_cp, op_dec, op_rep, a_in, f_in, bc_in, de_in, hl_in,
        output mem_rd_ack, mem_rd_data, mem_wr_ack,
        input  mem_rd_req, mem_rd_addr, mem_wr_req, mem_wr_addr, mem_wr_data,
        input  busy, done, bc_out, de_out, hl_out, f_out, iter_cnt
    );

    modport slave (
        input  start, op_cp, op_dec, op_rep, a_in, f_in, bc_in, de_in, hl_in,
        input  mem_rd_ack, mem_rd_data, mem_wr_ack,
        output mem_rd_req, mem_rd_addr, mem_wr_req, mem_wr_addr, mem_wr_data,
        output busy, done, bc_out, de_out, hl_out, f_out, iter_cnt
    );
`endif
endinterface

// File: rtl/z80_block_op_engine.sv
// Sequential engine for LDI/LDD/LDIR/LDDR and CPI/CPD/CPIR/CPDR with memory handshakes.
// Optional interrupt abort of repeat forms: define Z80_BLOCK_INTR_EN.
module z80_block_op_engine #(
    parameter int ADDR_W  = 16,
    parameter int CNT_W   = 16,
    parameter int GAP_CYC = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    z80_block_op_engine_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_WR, S_UPD, S_GAP, S_DONE
    } state_t;

    localparam logic [3:0] GAP_LD = 4'(GAP_CYC - 1);
    localparam int FS  = 7;
    localparam int FZ  = 6;
    localparam int FH  = 4;
    localparam int FPV = 2;
    localparam int FN  = 1;

    state_t            r_state;
    state_t            w_next;
    logic              r_cp;
    logic              r_dec;
    logic              r_rep;
    logic [7:0]        r_a;
    logic [7:0]        r_f;
    logic [7:0]        r_data;
    logic [CNT_W-1:0]  r_bc;
    logic [CNT_W-1:0]  r_iter;
    logic [ADDR_W-1:0] r_de;
    logic [ADDR_W-1:0] r_hl;
    logic [3:0]        r_gap;

    logic [CNT_W-1:0]  w_bc_new;
    logic [ADDR_W-1:0] w_hl_new;
    logic [ADDR_W-1:0] w_de_new;
    logic [7:0]        w_f_new;
    logic              w_cont;
    logic              w_irq;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [ADDR_W-1:0] step_ptr(input logic [ADDR_W-1:0] p, input logic dec);
        return dec ? p - ADDR_W'(1) : p + ADDR_W'(1);
    endfunction

    // 5, 3 and C always pass through; LD keeps S/Z as well.
    function automatic logic [7:0] calc_flags(input logic cp, input logic [7:0] f,
                                              input logic [7:0] a, input logic [7:0] d,
                                              input logic pv);
        logic [7:0] diff;
        logic [7:0] res;
        diff     = a - d;
        res      = f;
        res[FPV] = pv;
        if (cp) begin
            res[FS] = diff[7];
            res[FZ] = (diff == 8'h00);
            res[FH] = (a[3:0] < d[3:0]);
            res[FN] = 1'b1;
        end else begin
            res[FH] = 1'b0;
            res[FN] = 1'b0;
        end
        return res;
    endfunction

    always_comb begin
        w_bc_new = r_bc - CNT_W'(1);
        w_hl_new = step_ptr(r_hl, r_dec);
        w_de_new = r_cp ? r_de : step_ptr(r_de, r_dec);
        w_f_new  = calc_flags(r_cp, r_f, r_a, r_data, w_bc_new != '0);
        w_cont   = r_rep && (w_bc_new != '0) && !(r_cp && w_f_new[FZ]);
`ifdef Z80_BLOCK_INTR_EN
        w_irq    = w_cont && bus.int_pend;
`else
        w_irq    = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (bus.start)      w_next = S_RD;
            S_RD:   if (bus.mem_rd_ack) w_next = r_cp ? S_UPD : S_WR;
            S_WR:   if (bus.mem_wr_ack) w_next = S_UPD;
            S_UPD: begin
                if (!w_cont || w_irq) w_next = S_DONE;
                else if (GAP_CYC == 0) w_next = S_RD;
                else                   w_next = S_GAP;
            end
            S_GAP:  if (r_gap == 4'd0)  w_next = S_RD;
            S_DONE:                     w_next = S_IDLE;
            default:                    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.mem_rd_req = (r_state == S_RD);
        bus.mem_wr_req = (r_state == S_WR);
        bus.busy       = (r_state == S_RD) || (r_state == S_WR) ||
                         (r_state == S_UPD) || (r_state == S_GAP);
        bus.done       = (r_state == S_DONE);
    end

    // Working registers double as result outputs and memory addresses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cp   <= 1'b0;
            r_dec  <= 1'b0;
            r_rep  <= 1'b0;
            r_a    <= '0;
            r_f    <= '0;
            r_data <= '0;
            r_bc   <= '0;
            r_iter <= '0;
            r_de   <= '0;
            r_hl   <= '0;
            r_gap  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_cp   <= bus.op_cp;
                        r_dec  <= bus.op_dec;
                        r_rep  <= bus.op_rep;
                        r_a    <= bus.a_in;
                        r_f    <= bus.f_in;
                        r_bc   <= bus.bc_in;
                        r_de   <= bus.de_in;
                        r_hl   <= bus.hl_in;
                        r_iter <= '0;
                    end
                end
                S_RD: if (bus.mem_rd_ack) r_data <= bus.mem_rd_data;
                S_UPD: begin
                    r_hl   <= w_hl_new;
                    r_de   <= w_de_new;
                    r_bc   <= w_bc_new;
                    r_f    <= w_f_new;
                    r_iter <= sat_inc(r_iter);
                    r_gap  <= GAP_LD;
                end
                S_GAP: if (r_gap != 4'd0) r_gap <= r_gap - 4'd1;
                default: ;
            endcase
        end
    end

`ifdef Z80_BLOCK_INTR_EN
    logic r_intr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                r_intr <= 1'b0;
        else if (r_state == S_IDLE && bus.start)  r_intr <= 1'b0;
        else if (r_state == S_UPD)                r_intr <= w_irq;
    end

    assign bus.interrupted = r_intr;
`endif

    assign bus.mem_rd_addr = r_hl;
    assign bus.mem_wr_addr = r_de;
    assign bus.mem_wr_data = r_data;
    assign bus.bc_out      = r_bc;
    assign bus.de_out      = r_de;
    assign bus.hl_out      = r_hl;
    assign bus.f_out       = r_f;
    assign bus.iter_cnt    = r_iter;
endmodule

// File: tb/tb_z80_block_op_engine.sv
// Directed bench for z80_block_op_engine: memory responder plus result/write scoreboards.
module tb_z80_block_op_engine;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    z80_block_op_engine_if #(.ADDR_W(16), .CNT_W(16)) bus ();

    z80_block_op_engine #(.ADDR_W(16), .CNT_W(16), .GAP_CYC(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] bc;
        logic [15:0] de;
        logic [15:0] hl;
        logic [7:0]  f;
        logic [15:0] it;
        logic        intr;
    } res_t;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  d;
    } wr_t;

    res_t       exp_q[$];
    wr_t        wr_q[$];
    logic [7:0] mem  [0:65535];
    logic [7:0] wmem [0:65535];
    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int rd_dly  = 0;
    int wr_dly  = 0;
    int drops   = 0;
    logic prev_rd_req, prev_rd_ack, prev_wr_req, prev_wr_ack;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic responder();
        int rd_cnt = 0;
        int wr_cnt = 0;
        wr_t w;
        forever begin
            @(negedge clk);
            if (reset) begin
                rd_cnt = 0; wr_cnt = 0;
                bus.mem_rd_ack = 1'b0; bus.mem_wr_ack = 1'b0; bus.mem_rd_data = 8'h00;
                prev_rd_req = 1'b0; prev_rd_ack = 1'b0; prev_wr_req = 1'b0; prev_wr_ack = 1'b0;
            end else begin
                if (prev_rd_req && !prev_rd_ack && !bus.mem_rd_req) drops++;
                if (prev_wr_req && !prev_wr_ack && !bus.mem_wr_req) drops++;
                if (bus.mem_rd_req) begin
                    bus.mem_rd_ack  = (rd_cnt >= rd_dly);
                    bus.mem_rd_data = mem[bus.mem_rd_addr];
                    rd_cnt++;
                end else begin
                    bus.mem_rd_ack = 1'b0;
                    rd_cnt = 0;
                end
                if (bus.mem_wr_req) begin
                    bus.mem_wr_ack = (wr_cnt >= wr_dly);
                    if (bus.mem_wr_ack) begin
                        check("wr_expected", 32'(wr_q.size() != 0), 32'd1);
                        if (wr_q.size() != 0) begin
                            w = wr_q.pop_front();
                            check("wr_addr", 32'(bus.mem_wr_addr), 32'(w.addr));
                            check("wr_data", 32'(bus.mem_wr_data), 32'(w.d));
                        end
                        wmem[bus.mem_wr_addr] = bus.mem_wr_data;
                    end
                    wr_cnt++;
                end else begin
                    bus.mem_wr_ack = 1'b0;
                    wr_cnt = 0;
                end
                prev_rd_req = bus.mem_rd_req; prev_rd_ack = bus.mem_rd_ack;
                prev_wr_req = bus.mem_wr_req; prev_wr_ack = bus.mem_wr_ack;
            end
        end
    endtask

    // Reference behaviour of one whole instruction; pushes expected writes and the final result.
    task automatic model(input logic cp, input logic dec, input logic rep, input logic [7:0] a,
                         input logic [7:0] f, input logic [15:0] bc, input logic [15:0] de,
                         input logic [15:0] hl, input logic ip);
        res_t r;
        wr_t w;
        logic [7:0] d, diff;
        logic [15:0] it;
        logic cont;
        it = 16'd0;
        r.intr = 1'b0;
        do begin
            d = mem[hl];
            if (!cp) begin
                w.addr = de; w.d = d; wr_q.push_back(w);
                de = dec ? de - 16'd1 : de + 16'd1;
            end
            hl = dec ? hl - 16'd1 : hl + 16'd1;
            bc = bc - 16'd1;
            it = it + 16'd1;
            diff = a - d;
            f[2] = (bc != 16'd0);
            if (cp) begin
                f[7] = diff[7]; f[6] = (diff == 8'd0); f[4] = (a[3:0] < d[3:0]); f[1] = 1'b1;
            end else begin
                f[4] = 1'b0; f[1] = 1'b0;
            end
            cont = rep && (bc != 16'd0) && !(cp && f[6]);
            r.intr = cont && ip;
        end while (cont && !ip);
        r.bc = bc; r.de = de; r.hl = hl; r.f = f; r.it = it;
        exp_q.push_back(r);
    endtask

    task automatic launch(input logic cp, input logic dec, input logic rep, input logic [7:0] a,
                          input logic [7:0] f, input logic [15:0] bc, input logic [15:0] de,
                          input logic [15:0] hl);
        @(negedge clk);
        bus.start = 1'b1; bus.op_cp = cp; bus.op_dec = dec; bus.op_rep = rep;
        bus.a_in = a; bus.f_in = f; bus.bc_in = bc; bus.de_in = de; bus.hl_in = hl;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!bus.done && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        check("done_seen", 32'(bus.done), 32'd1);
    endtask

    task automatic check_result(input string tag);
        res_t r;
        r = exp_q.pop_front();
        check({tag, "_bc"},   32'(bus.bc_out),   32'(r.bc));
        check({tag, "_de"},   32'(bus.de_out),   32'(r.de));
        check({tag, "_hl"},   32'(bus.hl_out),   32'(r.hl));
        check({tag, "_f"},    32'(bus.f_out),    32'(r.f));
        check({tag, "_iter"}, 32'(bus.iter_cnt), 32'(r.it));
        check({tag, "_busy"}, 32'(bus.busy),     32'd0);
`ifdef Z80_BLOCK_INTR_EN
        check({tag, "_intr"}, 32'(bus.interrupted), 32'(r.intr));
`endif
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_busy"},  32'(bus.busy),        32'd0);
        check({tag, "_done"},  32'(bus.done),        32'd0);
        check({tag, "_rdreq"}, 32'(bus.mem_rd_req),  32'd0);
        check({tag, "_wrreq"}, 32'(bus.mem_wr_req),  32'd0);
        check({tag, "_bc"},    32'(bus.bc_out),      32'd0);
        check({tag, "_de"},    32'(bus.de_out),      32'd0);
        check({tag, "_hl"},    32'(bus.hl_out),      32'd0);
        check({tag, "_f"},     32'(bus.f_out),       32'd0);
        check({tag, "_iter"},  32'(bus.iter_cnt),    32'd0);
        check({tag, "_rdadr"}, 32'(bus.mem_rd_addr), 32'd0);
        check({tag, "_wradr"}, 32'(bus.mem_wr_addr), 32'd0);
        check({tag, "_wrdat"}, 32'(bus.mem_wr_data), 32'd0);
`ifdef Z80_BLOCK_INTR_EN
        check({tag, "_intr"},  32'(bus.interrupted), 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int drops0;
        int n;
        wr_t w;
        reset = 1'b1;
        bus.start = 1'b0; bus.op_cp = 1'b0; bus.op_dec = 1'b0; bus.op_rep = 1'b0;
        bus.a_in = 8'h00; bus.f_in = 8'h00; bus.bc_in = 16'h0; bus.de_in = 16'h0; bus.hl_in = 16'h0;
`ifdef Z80_BLOCK_INTR_EN
        bus.int_pend = 1'b0;
`endif
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'h00;
            wmem[i] = 8'h00;
        end
        fork
            responder();
        join_none
        repeat (2) @(negedge clk);
        chk_zero("rst");
        reset = 1'b0;

        // LDI, single byte, immediate acks
        mem[16'h1000] = 8'h5A;
        model(1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 16'd1, 16'h2000, 16'h1000, 1'b0);
        launch(1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 16'd1, 16'h2000, 16'h1000);
        check("ldi_busy", 32'(bus.busy), 32'd1);
        wait_done(lat);
        check("ldi_latency", 32'(lat), 32'd4);
        check_result("ldi");
        check("ldi_hl_const", 32'(bus.hl_out), 32'h1001);
        check("ldi_f_const", 32'(bus.f_out), 32'hE9);
        check("ldi_wmem", 32'(wmem[16'h2000]), 32'h5A);
        @(negedge clk);
        check("ldi_done_pulse", 32'(bus.done), 32'd0);
        check("ldi_hold_de", 32'(bus.de_out), 32'h2001);

        // LDDR, three bytes descending, with an ignored start while busy
        mem[16'h1000] = 8'hA1; mem[16'h1001] = 8'hB2; mem[16'h1002] = 8'hC3;
        model(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 16'd3, 16'h2002, 16'h1002, 1'b0);
        launch(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 16'd3, 16'h2002, 16'h1002);
        @(negedge clk);
        bus.start = 1'b1; bus.bc_in = 16'h0077; bus.hl_in = 16'h7777; bus.op_cp = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat);
        check_result("lddr");
        check("lddr_hl_const", 32'(bus.hl_out), 32'h0FFF);
        check("lddr_de_const", 32'(bus.de_out), 32'h1FFF);
        check("lddr_iter_const", 32'(bus.iter_cnt), 32'd3);
        check("lddr_wmem0", 32'(wmem[16'h2000]), 32'hA1);
        check("lddr_wmem2", 32'(wmem[16'h2002]), 32'hC3);

        // CPIR stops on match after three bytes
        mem[16'h3000] = 8'h11; mem[16'h3001] = 8'h22; mem[16'h3002] = 8'h33;
        mem[16'h3003] = 8'h44; mem[16'h3004] = 8'h55;
        model(1'b1, 1'b0, 1'b1, 8'h33, 8'h00, 16'd5, 16'hABCD, 16'h3000, 1'b0);
        launch(1'b1, 1'b0, 1'b1, 8'h33, 8'h00, 16'd5, 16'hABCD, 16'h3000);
        wait_done(lat);
        check_result("cpir");
        check("cpir_hl_const", 32'(bus.hl_out), 32'h3003);
        check("cpir_bc_const", 32'(bus.bc_out), 32'd2);
        check("cpir_f_const", 32'(bus.f_out), 32'h46);

        // CPI half-borrow with pass-through flag bits
        mem[16'h3100] = 8'h01;
        model(1'b1, 1'b0, 1'b0, 8'h10, 8'h29, 16'd1, 16'h0000, 16'h3100, 1'b0);
        launch(1'b1, 1'b0, 1'b0, 8'h10, 8'h29, 16'd1, 16'h0000, 16'h3100);
        wait_done(lat);
        check("cpi_latency", 32'(lat), 32'd3);
        check_result("cpi");
        check("cpi_f_const", 32'(bus.f_out), 32'h3B);

        // LDIR with BC=0 and slow acks, aborted by reset after four iterations
        for (int i = 0; i < 4; i++) begin
            mem[16'h4000 + 16'(i)] = 8'h10 + 8'(i);
            w.addr = 16'h5000 + 16'(i);
            w.d = 8'h10 + 8'(i);
            wr_q.push_back(w);
        end
        rd_dly = 2; wr_dly = 2;
        drops0 = drops;
        launch(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 16'd0, 16'h5000, 16'h4000);
        n = 0;
        while (bus.iter_cnt != 16'd4 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("ldir_iter", 32'(bus.iter_cnt), 32'd4);
        check("ldir_bc_wrap", 32'(bus.bc_out), 32'hFFFC);
        check("ldir_hl", 32'(bus.hl_out), 32'h4004);
        check("ldir_de", 32'(bus.de_out), 32'h5004);
        check("ldir_busy", 32'(bus.busy), 32'd1);
        check("ldir_no_drop", 32'(drops - drops0), 32'd0);
        check("ldir_wmem3", 32'(wmem[16'h5003]), 32'h13);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("abort");
        @(negedge clk);
        reset = 1'b0;
        rd_dly = 0; wr_dly = 0;

`ifdef Z80_BLOCK_INTR_EN
        // CPIR interrupted after the first iteration, then a normal CPI with int_pend ignored
        mem[16'h6000] = 8'h01; mem[16'h6001] = 8'h02; mem[16'h6002] = 8'h03; mem[16'h6003] = 8'h04;
        bus.int_pend = 1'b1;
        model(1'b1, 1'b0, 1'b1, 8'h80, 8'h00, 16'd4, 16'h0000, 16'h6000, 1'b1);
        launch(1'b1, 1'b0, 1'b1, 8'h80, 8'h00, 16'd4, 16'h0000, 16'h6000);
        wait_done(lat);
        check_result("intr");
        check("intr_flag_const", 32'(bus.interrupted), 32'd1);
        check("intr_bc_const", 32'(bus.bc_out), 32'd3);
        check("intr_hl_const", 32'(bus.hl_out), 32'h6001);
        model(1'b1, 1'b0, 1'b0, 8'h80, 8'h00, 16'd4, 16'h0000, 16'h6000, 1'b0);
        launch(1'b1, 1'b0, 1'b0, 8'h80, 8'h00, 16'd4, 16'h0000, 16'h6000);
        wait_done(lat);
        check_result("cpi_nointr");
        bus.int_pend = 1'b0;
`endif

        check("wr_q_empty", 32'(wr_q.size()), 32'd0);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
